// File: rtl/regfile_write_port_pkg.sv
// rtl/regfile_write_port_pkg.sv - shared constants and types for the register-file write port
package regfile_write_port_pkg;

  localparam int NUM_REGS = 32;
  localparam int ADDR_W   = 5;
  localparam int DATA_W   = 32;
  localparam int CNT_W    = 16;

  typedef logic [DATA_W-1:0] word_t;
  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [CNT_W-1:0]  cnt_t;
  typedef word_t [NUM_REGS-1:0] rf_t;

endpackage

// File: rtl/regfile_write_port_decoder5_32.sv
// rtl/regfile_write_port_decoder5_32.sv - 5-to-32 one-hot write-enable decoder
module decoder5_32
  import regfile_write_port_pkg::*;
(
  input  logic                en_i,
  input  addr_t               addr_i,
  output logic [NUM_REGS-1:0] onehot_o
);

  always_comb begin
    onehot_o = '0;
    for (int k = 0; k < NUM_REGS; k++) begin
      onehot_o[k] = en_i && (addr_i == ADDR_W'(k));
    end
  end

endmodule

// File: rtl/regfile_write_port.sv
// rtl/regfile_write_port.sv - 32x32 register file write side with forwarding and commit counter
module regfile_write_port
  import regfile_write_port_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  wr_en,
  input  addr_t wr_addr,
  input  word_t wr_data,
  output rf_t   RF,
  output logic  fwd_valid,
  output addr_t fwd_addr,
  output word_t fwd_data,
  output cnt_t  wr_count
);

  logic [NUM_REGS-1:0] enable;
  logic                commit;

  logic  fwd_valid_q, fwd_valid_d;
  addr_t fwd_addr_q,  fwd_addr_d;
  word_t fwd_data_q,  fwd_data_d;
  cnt_t  wr_count_q,  wr_count_d;

  decoder5_32 u_decoder (
    .en_i     (wr_en),
    .addr_i   (wr_addr),
    .onehot_o (enable)
  );

  // A write to register 0 decodes but is discarded, so it never commits.
  assign commit = (|enable) && !enable[0];

  assign RF[0] = '0;

  for (genvar k = 1; k < NUM_REGS; k++) begin : g_row
    word_t row_q;

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        row_q <= '0;
      end else if (enable[k]) begin
        row_q <= wr_data;
      end
    end

    assign RF[k] = row_q;
  end

  always_comb begin
    fwd_valid_d = commit;
    fwd_addr_d  = fwd_addr_q;
    fwd_data_d  = fwd_data_q;
    wr_count_d  = wr_count_q;
    if (commit) begin
      fwd_addr_d = wr_addr;
      fwd_data_d = wr_data;
      wr_count_d = wr_count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fwd_valid_q <= 1'b0;
      fwd_addr_q  <= '0;
      fwd_data_q  <= '0;
      wr_count_q  <= '0;
    end else begin
      fwd_valid_q <= fwd_valid_d;
      fwd_addr_q  <= fwd_addr_d;
      fwd_data_q  <= fwd_data_d;
      wr_count_q  <= wr_count_d;
    end
  end

  assign fwd_valid = fwd_valid_q;
  assign fwd_addr  = fwd_addr_q;
  assign fwd_data  = fwd_data_q;
  assign wr_count  = wr_count_q;

endmodule

// File: tb/tb_regfile_write_port.sv
// tb/tb_regfile_write_port.sv - directed self-checking bench for regfile_write_port
module tb_regfile_write_port;
  import regfile_write_port_pkg::*;

  logic  clk;
  logic  rst_n;
  logic  wr_en;
  addr_t wr_addr;
  word_t wr_data;
  rf_t   RF;
  logic  fwd_valid;
  addr_t fwd_addr;
  word_t fwd_data;
  cnt_t  wr_count;

  int n_checks;
  int n_pass;

  regfile_write_port dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .RF        (RF),
    .fwd_valid (fwd_valid),
    .fwd_addr  (fwd_addr),
    .fwd_data  (fwd_data),
    .wr_count  (wr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Present inputs, take one rising edge, then settle away from the edge.
  task automatic cycle(input logic en, input logic [4:0] addr, input logic [31:0] data);
    wr_en   = en;
    wr_addr = addr;
    wr_data = data;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cycle(1'b0, 5'd0, 32'h0);
    cycle(1'b0, 5'd0, 32'h0);
    rst_n = 1'b1;
  endtask

  function automatic int nonzero_rows_except(input rf_t rf, input int skip);
    int n;
    n = 0;
    for (int k = 0; k < NUM_REGS; k++) begin
      if (k != skip && rf[k] != '0) n++;
    end
    return n;
  endfunction

  initial begin
    logic [31:0] exp_onehot;
    n_checks = 0;
    n_pass   = 0;
    rst_n    = 1'b0;
    wr_en    = 1'b0;
    wr_addr  = '0;
    wr_data  = '0;
    #1;

    do_reset();
    check("rst_rows_nonzero", 32'(nonzero_rows_except(RF, -1)), 32'd0);
    check("rst_fwd_valid", 32'(fwd_valid), 32'd0);
    check("rst_fwd_addr", 32'(fwd_addr), 32'd0);
    check("rst_fwd_data", fwd_data, 32'd0);
    check("rst_wr_count", 32'(wr_count), 32'd0);

    cycle(1'b1, 5'd5, 32'hDEADBEEF);
    check("w5_rf5", RF[5], 32'hDEADBEEF);
    check("w5_fwd_valid", 32'(fwd_valid), 32'd1);
    check("w5_fwd_addr", 32'(fwd_addr), 32'd5);
    check("w5_fwd_data", fwd_data, 32'hDEADBEEF);
    check("w5_wr_count", 32'(wr_count), 32'd1);
    check("w5_other_rows", 32'(nonzero_rows_except(RF, 5)), 32'd0);

    cycle(1'b0, 5'd9, 32'hAAAA5555);
    check("idle_fwd_valid", 32'(fwd_valid), 32'd0);
    check("idle_fwd_addr_hold", 32'(fwd_addr), 32'd5);
    check("idle_fwd_data_hold", fwd_data, 32'hDEADBEEF);
    check("idle_rf9", RF[9], 32'd0);
    check("idle_wr_count", 32'(wr_count), 32'd1);

    cycle(1'b1, 5'd0, 32'hFFFFFFFF);
    check("w0_rf0", RF[0], 32'd0);
    check("w0_fwd_valid", 32'(fwd_valid), 32'd0);
    check("w0_wr_count", 32'(wr_count), 32'd1);
    check("w0_fwd_addr_hold", 32'(fwd_addr), 32'd5);

    cycle(1'b1, 5'd7, 32'd1);
    check("b2b_first_valid", 32'(fwd_valid), 32'd1);
    check("b2b_first_rf7", RF[7], 32'd1);
    cycle(1'b1, 5'd7, 32'd2);
    check("b2b_second_valid", 32'(fwd_valid), 32'd1);
    check("b2b_rf7", RF[7], 32'd2);
    check("b2b_fwd_data", fwd_data, 32'd2);
    check("b2b_wr_count", 32'(wr_count), 32'd3);

    rst_n = 1'b0;
    cycle(1'b1, 5'd3, 32'h12345678);
    check("rstwr_rf3", RF[3], 32'd0);
    check("rstwr_rf7", RF[7], 32'd0);
    check("rstwr_wr_count", 32'(wr_count), 32'd0);
    check("rstwr_fwd_valid", 32'(fwd_valid), 32'd0);

    rst_n = 1'b1;
    cycle(1'b1, 5'd3, 32'h12345678);
    check("first_after_rst_rf3", RF[3], 32'h12345678);
    check("first_after_rst_count", 32'(wr_count), 32'd1);
    check("first_after_rst_valid", 32'(fwd_valid), 32'd1);

    do_reset();
    wr_en = 1'b0;
    wr_addr = 5'd17;
    #1;
    check("onehot_idle", dut.enable, 32'd0);
    for (int k = 1; k < NUM_REGS; k++) begin
      wr_en   = 1'b1;
      wr_addr = 5'(k);
      wr_data = 32'(k);
      #1;
      exp_onehot = 32'd1 << k;
      check($sformatf("onehot_a%0d", k), dut.enable, exp_onehot);
      @(posedge clk);
      #1;
      check($sformatf("sweep_valid_a%0d", k), 32'(fwd_valid), 32'd1);
    end
    wr_en = 1'b0;
    for (int k = 0; k < NUM_REGS; k++) begin
      check($sformatf("sweep_rf%0d", k), RF[k], 32'(k));
    end
    check("sweep_wr_count", 32'(wr_count), 32'd31);

    do_reset();
    for (int i = 0; i < 65535; i++) begin
      wr_en   = 1'b1;
      wr_addr = 5'((i % 31) + 1);
      wr_data = 32'(i);
      @(posedge clk);
    end
    #1;
    check("wrap_pre_count", 32'(wr_count), 32'h0000FFFF);
    cycle(1'b1, 5'd12, 32'hCAFEF00D);
    check("wrap_count", 32'(wr_count), 32'h00000000);
    check("wrap_fwd_valid", 32'(fwd_valid), 32'd1);
    check("wrap_rf12", RF[12], 32'hCAFEF00D);
    wr_en = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/regfile_write_port.md
REGFILE_WRITE_PORT -- requirements
Module: regfile_write_port

Interface
REQ-001: The block SHALL use one clock and a synchronous, active-low reset, with ports named clk and rst_n.
REQ-002: clk  input  1  rising-edge clock for all state.
REQ-003: rst_n  input  1  synchronous active-low reset, sampled on the clk rising edge.
REQ-004: wr_en  input  1  write request for the current cycle.
REQ-005: wr_addr  input  5  destination register index, 0..31.
REQ-006: wr_data  input  32  write data.
REQ-007: RF  output  32 words x 32 bits  register array, one word per row, row k = register k; it feeds the read-side 32-to-1 word mux.
REQ-008: fwd_valid  output  1  a write committed on the previous edge.
REQ-009: fwd_addr  output  5  index of that committed write.
REQ-010: fwd_data  output  32  data of that committed write.
REQ-011: wr_count  output  16  count of committed writes since reset.

Function
REQ-012: A 5-to-32 one-hot decoder SHALL drive enable[k] = wr_en AND (wr_addr == k), and exactly zero or one enable SHALL be high in any cycle.
REQ-013: On a rising edge with rst_n=1 and enable[k]=1 for k!=0, register k SHALL load wr_data; all other rows SHALL hold their value.
REQ-014: Register 0 SHALL always read 32'h0; a write to address 0 SHALL be a no-op and SHALL not count as committed.
REQ-015: The write latency SHALL be one edge: RF[k] reflects new data from the cycle after the edge on which the write was sampled; the block SHALL provide no same-cycle bypass inside RF.
REQ-016: fwd_valid SHALL be registered as wr_en AND (wr_addr != 0); fwd_addr and fwd_data SHALL load on committed writes only and hold otherwise.
REQ-017: fwd_valid SHALL be high for exactly one cycle per committed write and SHALL stay high across back-to-back committed writes.
REQ-018: wr_count SHALL increment by 1 per committed write and SHALL wrap from 16'hFFFF to 16'h0000 without saturating.
REQ-019: Back-to-back writes to the same address SHALL leave the last-written value.
REQ-020: When wr_en=0, wr_addr and wr_data SHALL be don't-care and SHALL cause no state change.

Reset
REQ-021: With rst_n=0 on an edge, all RF rows, fwd_valid, fwd_addr, fwd_data, and wr_count SHALL become 0.
REQ-022: Reset SHALL take priority over a simultaneous write; the write SHALL be dropped and not counted.
REQ-023: The first write accepted after rst_n rises SHALL behave per REQ-013 with no warm-up cycle.

Structure
REQ-024: A shared package SHALL hold the constants NUM_REGS=32, ADDR_W=5, DATA_W=32, CNT_W=16, and the word typedef.
REQ-025: The decoder SHALL be a separate sub-module named decoder5_32, instantiated once.
REQ-026: Storage SHALL use per-row enabled flops; row 0 SHALL be constant zero and have no flops.

Verification
REQ-027: Reset, then write addr 5 data 32'hDEADBEEF -> next cycle RF[5]=32'hDEADBEEF, fwd_valid=1, fwd_addr=5, wr_count=1, all other rows=0.
REQ-028: Write addr 0 data 32'hFFFFFFFF -> RF[0]=0, fwd_valid=0, wr_count unchanged.
REQ-029: Write addr 7 data 1 then addr 7 data 2 on consecutive cycles -> RF[7]=2, fwd_valid high both cycles, wr_count +2.
REQ-030: Hold rst_n=0 with wr_en=1, addr 3, data 32'h12345678 -> RF[3]=0, wr_count=0, fwd_valid=0.
REQ-031: Write addresses 1..31 with data = address on consecutive cycles -> RF[k]=k for all k, one-hot enable checked every cycle, wr_count=31.
REQ-032: Preload wr_count to 16'hFFFF via 65535 committed writes, then one more write -> wr_count=16'h0000.
